// File: rtl/program_loader.sv
// program_loader: boot-time writer for the MUSA instruction memory.
// Parses a length / big-endian words / XOR-checksum byte frame and releases core reset on success.
module program_loader #(
  parameter int ADDR_WIDTH = 18,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready. rx_ready is a
  // registered decode of the state (high in LEN, DATA, CSUM) and never looks at rx_valid.

  // Largest word count that still fits between START_ADDR and the top of memory.
  localparam logic [63:0] LEN_LIMIT = (64'd1 << ADDR_WIDTH) - 64'(START_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [23:0] len_q;
  logic [23:0] rem_q;
  logic [7:0]  csum_q;

  logic        xfer;
  logic [23:0] len_next;
  logic        len_last;
  logic        word_last;
  logic        len_oversize;

  assign xfer         = rx_valid && rx_ready;
  assign len_next     = {len_q[15:0], rx_data};
  assign len_last     = xfer && (byte_cnt_q == 2'd2);
  assign word_last    = xfer && (byte_cnt_q == 2'd3);
  assign len_oversize = 64'(len_next) > LEN_LIMIT;
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (len_last) begin
          if (len_next == 24'd0)  state_d = S_CSUM;
          else if (len_oversize)  state_d = S_ERR;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = (rem_q == 24'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are loaded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready   <= 1'b0;
      imem_wren  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      rx_ready   <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      imem_wren  <= (state_d == S_WRITE);
      busy       <= (state_d == S_LEN) || (state_d == S_DATA) ||
                    (state_d == S_WRITE) || (state_d == S_CSUM);
      done       <= (state_d == S_DONE);
      error      <= (state_d == S_ERR);
      core_rst_n <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q   <= 2'd0;
      len_q        <= 24'd0;
      rem_q        <= 24'd0;
      csum_q       <= 8'd0;
      imem_data    <= 32'd0;
      imem_address <= ADDR_WIDTH'(START_ADDR);
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            byte_cnt_q   <= 2'd0;
            len_q        <= 24'd0;
            csum_q       <= 8'd0;
            imem_address <= ADDR_WIDTH'(START_ADDR);
          end
        end
        S_LEN: begin
          if (xfer) begin
            len_q      <= len_next;
            byte_cnt_q <= len_last ? 2'd0 : byte_cnt_q + 2'd1;
            if (len_last) rem_q <= len_next;
          end
        end
        S_DATA: begin
          // Word register doubles as the write-data output; 2-bit counter wraps after byte 4.
          if (xfer) begin
            imem_data  <= {imem_data[23:0], rx_data};
            csum_q     <= csum_q ^ rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          imem_address <= imem_address + ADDR_WIDTH'(1);
          rem_q        <= rem_q - 24'd1;
        end
        default: begin
        end
      endcase
    end
  end

  a_wren_single: assert property (@(posedge clk) disable iff (!rst_n) imem_wren |=> !imem_wren);
  a_ready_busy:  assert property (@(posedge clk) disable iff (!rst_n) rx_ready |-> busy);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: frame-level reference model and per-cycle write scoreboard for program_loader.
module tb_program_loader;
  localparam int AW = 18;
  localparam int SA = 0;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_wren, core_rst_n, busy, done, error;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;
  logic [2:0]    dbg_state;

  program_loader #(.ADDR_WIDTH(AW), .START_ADDR(SA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_address(imem_address), .imem_data(imem_data),
    .imem_wren(imem_wren), .core_rst_n(core_rst_n), .busy(busy), .done(done),
    .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int wr_count = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words_q[$];
  logic [7:0]     frame_q[$];
  logic [AW-1:0]  last_addr = '0;
  logic [31:0]    last_data = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && imem_wren) begin
      wr_count++;
      last_addr = imem_address;
      last_data = imem_data;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wren got addr=%0h data=%0h exp none", imem_address, imem_data);
      end else begin
        check("imem_write", 64'({imem_address, imem_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},   64'(rx_ready),     64'(0));
    check({tag, "_wren"},       64'(imem_wren),    64'(0));
    check({tag, "_addr"},       64'(imem_address), 64'(SA));
    check({tag, "_data"},       64'(imem_data),    64'(0));
    check({tag, "_core_rst_n"}, 64'(core_rst_n),   64'(0));
    check({tag, "_busy"},       64'(busy),         64'(0));
    check({tag, "_done"},       64'(done),         64'(0));
    check({tag, "_error"},      64'(error),        64'(0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int n;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (pulse) pulse_start();
    repeat (gap) begin
      @(posedge clk); #1;
      rx_data = 8'($urandom);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout got ready=0 exp ready=1 byte=%0h", b);
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Reference model: frame bytes, expected writes and outcome straight from the frame rules.
  task automatic build_frame(input logic [7:0] mask, output bit ok);
    logic [7:0] x = 8'h00;
    int n = words_q.size();
    frame_q.delete();
    frame_q.push_back(8'(n >> 16));
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    foreach (words_q[i]) begin
      exp_q.push_back({AW'(SA + i), words_q[i]});
      for (int k = 3; k >= 0; k--) begin
        frame_q.push_back(8'(words_q[i] >> (8 * k)));
        x = x ^ 8'(words_q[i] >> (8 * k));
      end
    end
    frame_q.push_back(x ^ mask);
    ok = ((x ^ mask) == x);
  endtask

  task automatic run_frame(input bit exp_ok, input int max_gap, input int mid_at);
    pulse_start();
    check("start_busy",        64'(busy),  64'(1));
    check("start_clears_done", 64'(done),  64'(0));
    check("start_clears_err",  64'(error), 64'(0));
    foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap), i == mid_at);
    check("result_done",       64'(done),         64'(exp_ok));
    check("result_error",      64'(error),        64'(!exp_ok));
    check("result_core_rst_n", 64'(core_rst_n),   64'(exp_ok));
    check("result_busy",       64'(busy),         64'(0));
    check("writes_drained",    64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bit         ok;
    int         wr0;
    int         n;
    logic [7:0] mask;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rx_ready", 64'(rx_ready), 64'(0));

    frame_q = '{8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    exp_q.push_back({AW'(0), 32'hDEADBEEF});
    wr0 = wr_count;
    run_frame(1'b1, 0, -1);
    check("single_wr_count", 64'(wr_count - wr0), 64'(1));
    check("single_data",     64'(last_data),      64'h DEADBEEF);
    check("single_addr",     64'(last_addr),      64'(0));

    frame_q = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    exp_q.push_back({AW'(0), 32'h1});
    exp_q.push_back({AW'(1), 32'h2});
    exp_q.push_back({AW'(2), 32'h3});
    wr0 = wr_count;
    run_frame(1'b1, 0, -1);
    check("three_wr_count", 64'(wr_count - wr0), 64'(3));
    check("three_last_addr", 64'(last_addr), 64'(2));

    frame_q = '{8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    exp_q.push_back({AW'(0), 32'h12345678});
    wr0 = wr_count;
    run_frame(1'b0, 0, -1);
    check("badcs_wr_count", 64'(wr_count - wr0), 64'(1));
    repeat (5) begin
      @(posedge clk); #1;
      check("badcs_rx_ready_low", 64'(rx_ready), 64'(0));
    end

    frame_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    wr0 = wr_count;
    run_frame(1'b1, 2, -1);
    check("zero_wr_count", 64'(wr_count - wr0), 64'(0));

    wr0 = wr_count;
    pulse_start();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 1, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    check("oversize_error",    64'(error),      64'(1));
    check("oversize_done",     64'(done),       64'(0));
    check("oversize_busy",     64'(busy),       64'(0));
    check("oversize_rx_ready", 64'(rx_ready),   64'(0));
    check("oversize_core_rst", 64'(core_rst_n), 64'(0));
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    repeat (4) @(posedge clk);
    #1 rx_valid = 1'b0;
    check("oversize_still_err", 64'(error), 64'(1));
    check("oversize_wr_count",  64'(wr_count - wr0), 64'(0));

    for (int it = 0; it < 6; it++) begin
      words_q.delete();
      n = $urandom_range(1, 6);
      repeat (n) words_q.push_back($urandom);
      mask = (it != 0 && $urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      build_frame(mask, ok);
      wr0 = wr_count;
      run_frame(ok, 0, -1);
      check("rand_wr_count", 64'(wr_count - wr0), 64'(n));
      build_frame(mask, ok);
      wr0 = wr_count;
      run_frame(ok, 7, $urandom_range(3, frame_q.size() - 2));
      check("rand_gap_wr_count", 64'(wr_count - wr0), 64'(n));
    end

    words_q.delete();
    repeat (3) words_q.push_back($urandom);
    build_frame(8'h00, ok);
    wr0 = wr_count;
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(frame_q[i], $urandom_range(0, 3), 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midload_reset");
    check("midload_wr_count", 64'(wr_count - wr0), 64'(1));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    words_q.delete();
    repeat (4) words_q.push_back($urandom);
    build_frame(8'h00, ok);
    wr0 = wr_count;
    run_frame(ok, 3, -1);
    check("post_reset_wr_count", 64'(wr_count - wr0), 64'(4));
    check("post_reset_last_addr", 64'(last_addr), 64'(SA + 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog got timeout exp finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
